dram_arbiter: RTL and testbench
===============================

Name: dram_arbiter

Overview:
- Shares the single dram port between two requesters: the cpu data port (M0) and an SPI-side host debug/DMA port (M1).
- Sits between the cpu, a host requester and dram. It grants one access per cycle, drives the dram enables, address, data and byte enables, and routes read data back to the owner after a fixed read latency.
- Arbitration is fixed-priority: M0 wins. An optional starvation guard bounds M1 wait time.

Parameters:
- XLEN, 32, data width of both requesters and dram.
- AW, 32, address width.
- RD_LAT, 1, dram read latency in cycles (rd_en to rd_data valid); legal range 1..4.
- MAX_WAIT, 15, consecutive M1 stall cycles before M1 is forced priority (optional feature only).

Ports:
- clk_i  in  1  system clock
- rst_n_i  in  1  asynchronous active-low reset
- m0_req_i  in  1  M0 access request
- m0_we_i  in  1  M0 write (1) / read (0)
- m0_addr_i  in  AW  M0 address
- m0_wr_data_i  in  XLEN  M0 write data
- m0_byte_en_i  in  XLEN/8  M0 write byte enables
- m0_gnt_o  out  1  M0 request accepted this cycle
- m0_rd_valid_o  out  1  M0 read data valid
- m0_rd_data_o  out  XLEN  M0 read data
- m1_*  same set as m0_*  M1 host requester
- dram_rd_en_o  out  1  dram read enable
- dram_rd_addr_o  out  AW  dram read address
- dram_wr_en_o  out  1  dram write enable
- dram_wr_addr_o  out  AW  dram write address
- dram_wr_data_o  out  XLEN  dram write data
- dram_wr_byte_en_o  out  XLEN/8  dram byte enables
- dram_rd_data_i  in  XLEN  dram read data

Behaviour:
- Reset (async assert): arb_en_q=0, owner pipe cleared, starvation counter=0.
- While reset is asserted, or arb_en_q=0, all outputs are 0: gnt, rd_valid, rd_data, dram enables, addr, data, byte_en.
- arb_en_q sets on the first clk_i edge after reset deasserts. No grant is issued in that first cycle.
- Grant is combinational in the request cycle: m0_gnt_o = arb_en_q & m0_req_i & ~force_m1; m1_gnt_o = arb_en_q & m1_req_i & (~m0_req_i | force_m1).
- At most one gnt per cycle; both gnt=1 is illegal and is asserted against.
- Granted access is issued to dram in the same cycle.
  - Write: dram_wr_en_o=1, wr_addr/data/byte_en from the winner.
  - Read: dram_rd_en_o=1, rd_addr from the winner.
  - Write and read enables are never both 1.
  - With no grant, all dram outputs are 0.
- Requester holds req/we/addr/data/byte_en stable until gnt. Deasserting req before gnt is allowed; nothing is issued.
- Back-to-back: a requester may keep req high across cycles; each gnt cycle is one access. Fully pipelined, one access per cycle.
- Read return: the owner tag (NONE/M0/M1) of each issued read is shifted through an RD_LAT-deep pipe.
  - Exactly RD_LAT cycles after issue, the owner's rd_valid_o=1 and rd_data_o=dram_rd_data_i.
  - Non-owner rd_data_o=0, rd_valid_o=0.
  - Writes push the NONE tag and produce no rd_valid.
- Reset mid-operation: in-flight reads are dropped and no rd_valid is produced for them afterwards.
- Read return order per requester equals issue order.

Optional Feature:
- Macro DRAM_ARBITER_STARVE_EN.
- Defined:
  - 4-bit-wide (clog2(MAX_WAIT+1)) counter wait_cnt increments each cycle m1_req_i & ~m1_gnt_o, saturating at MAX_WAIT.
  - force_m1 = (wait_cnt == MAX_WAIT).
  - wait_cnt clears on m1_gnt_o or when m1_req_i=0.
  - Result: M1 waits at most MAX_WAIT cycles, then wins exactly one cycle.
- Undefined: force_m1 is tied 0, the counter is absent, and M1 can starve indefinitely.

Decomposition:
- Package dram_arbiter_pkg:
  - typedef enum logic [1:0] owner_t {OWN_NONE, OWN_M0, OWN_M1};
  - localparam RD_LAT_MAX=4.
- One sub-module, rd_owner_pipe: RD_LAT-deep owner_t shift register with async reset, input tag, output tag.

Test Plan:
- Reset release, both req=1 in first cycle -> no gnt that cycle; next cycle m0_gnt_o=1, m1_gnt_o=0.
- M0 read addr 0x10 only, dram returns 0xDEADBEEF, RD_LAT=1 -> dram_rd_en_o=1 in cycle T; m0_rd_valid_o=1 with 0xDEADBEEF at T+1; m1_rd_valid_o=0.
- Alternating M0 write (0x20, 0x11223344, be=4'b0011) then M1 read 0x20 on consecutive cycles -> one dram op per cycle, correct enables and byte_en; M1 rd_valid at issue+RD_LAT.
- Both req held high 40 cycles -> without macro, M1 never granted. With DRAM_ARBITER_STARVE_EN and MAX_WAIT=15: M1 granted on its 16th request cycle, then M0 again.
- RD_LAT=3, M0 read, M1 read, write on 3 consecutive cycles -> rd_valid on M0 at +3, M1 at +4, nothing at +5.
- Assert rst_n_i one cycle after an M0 read issue with RD_LAT=2 -> all outputs 0 immediately; no m0_rd_valid_o after release.

Source files
------------

// File: rtl/dram_arbiter_pkg.sv
// rtl/dram_arbiter_pkg.sv - shared types and limits for the dram arbiter
package dram_arbiter_pkg;

    // Owner tag carried alongside every issued dram access so read data can be
    // routed back to the requester that issued the read.
    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } owner_t;

    // Deepest supported dram read latency.
    localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/dram_arbiter_rd_owner_pipe.sv
// rtl/dram_arbiter_rd_owner_pipe.sv - read-owner tag delay line
//
// Delays an owner tag by DEPTH cycles.
// Ports:
//   clk_i    system clock
//   rst_n_i  asynchronous active-low reset, clears every stage to OWN_NONE
//   tag_i    tag entering the pipe this cycle
//   tag_o    tag that entered DEPTH cycles ago
module rd_owner_pipe
    import dram_arbiter_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic   clk_i,
    input  logic   rst_n_i,
    input  owner_t tag_i,
    output owner_t tag_o
);

    owner_t stage_q [DEPTH];
    owner_t stage_d [DEPTH];

    always_comb begin
        stage_d[0] = tag_i;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= OWN_NONE;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dram_arbiter.sv
// rtl/dram_arbiter.sv - fixed-priority two-port arbiter in front of a single dram port
//
// M0 (cpu data port) has priority over M1 (host debug/DMA port). One access is
// granted and issued to dram per cycle; read data returns RD_LAT cycles later
// and is steered to the requester that issued the read.
// Optional macro DRAM_ARBITER_STARVE_EN: M1 that has stalled MAX_WAIT
// consecutive cycles wins the next cycle.
// Ports:
//   clk_i, rst_n_i                      clock, asynchronous active-low reset
//   m{0,1}_req_i/we_i/addr_i/wr_data_i/byte_en_i   requester access
//   m{0,1}_gnt_o                        access accepted this cycle
//   m{0,1}_rd_valid_o/rd_data_o         read return to the owning requester
//   dram_rd_en_o/rd_addr_o              dram read command
//   dram_wr_en_o/wr_addr_o/wr_data_o/wr_byte_en_o  dram write command
//   dram_rd_data_i                      dram read data
module dram_arbiter
    import dram_arbiter_pkg::*;
#(
    parameter int XLEN     = 32,
    parameter int AW       = 32,
    parameter int RD_LAT   = 1,
    parameter int MAX_WAIT = 15
) (
    input  logic              clk_i,
    input  logic              rst_n_i,

    input  logic              m0_req_i,
    input  logic              m0_we_i,
    input  logic [AW-1:0]     m0_addr_i,
    input  logic [XLEN-1:0]   m0_wr_data_i,
    input  logic [XLEN/8-1:0] m0_byte_en_i,
    output logic              m0_gnt_o,
    output logic              m0_rd_valid_o,
    output logic [XLEN-1:0]   m0_rd_data_o,

    input  logic              m1_req_i,
    input  logic              m1_we_i,
    input  logic [AW-1:0]     m1_addr_i,
    input  logic [XLEN-1:0]   m1_wr_data_i,
    input  logic [XLEN/8-1:0] m1_byte_en_i,
    output logic              m1_gnt_o,
    output logic              m1_rd_valid_o,
    output logic [XLEN-1:0]   m1_rd_data_o,

    output logic              dram_rd_en_o,
    output logic [AW-1:0]     dram_rd_addr_o,
    output logic              dram_wr_en_o,
    output logic [AW-1:0]     dram_wr_addr_o,
    output logic [XLEN-1:0]   dram_wr_data_o,
    output logic [XLEN/8-1:0] dram_wr_byte_en_o,
    input  logic [XLEN-1:0]   dram_rd_data_i
);

    // Out-of-range latencies are clamped into 1..RD_LAT_MAX.
    localparam int PIPE_DEPTH = (RD_LAT < 1) ? 1 :
                                (RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT;

    logic   arb_en_q, arb_en_d;
    logic   force_m1;
    logic   any_gnt;
    logic   sel_we;
    owner_t tag_in;
    owner_t tag_out;

    // Arbitration is held off for the first cycle after reset release.
    assign arb_en_d = 1'b1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            arb_en_q <= 1'b0;
        end else begin
            arb_en_q <= arb_en_d;
        end
    end

`ifdef DRAM_ARBITER_STARVE_EN
    localparam int WW = $clog2(MAX_WAIT + 1);

    logic [WW-1:0] wait_cnt_q, wait_cnt_d;

    // Counts consecutive cycles M1 asks but is not served; saturates so that
    // force_m1 stays up until M1 is actually granted or withdraws.
    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (!m1_req_i || m1_gnt_o) begin
            wait_cnt_d = '0;
        end else if (wait_cnt_q != WW'(MAX_WAIT)) begin
            wait_cnt_d = wait_cnt_q + WW'(1);
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign force_m1 = (wait_cnt_q == WW'(MAX_WAIT));
`else
    assign force_m1 = 1'b0;
`endif

    assign m0_gnt_o = arb_en_q & m0_req_i & ~force_m1;
    assign m1_gnt_o = arb_en_q & m1_req_i & (~m0_req_i | force_m1);
    assign any_gnt  = m0_gnt_o | m1_gnt_o;
    assign sel_we   = m0_gnt_o ? m0_we_i : m1_we_i;

    always_comb begin
        dram_rd_en_o      = 1'b0;
        dram_rd_addr_o    = '0;
        dram_wr_en_o      = 1'b0;
        dram_wr_addr_o    = '0;
        dram_wr_data_o    = '0;
        dram_wr_byte_en_o = '0;
        tag_in            = OWN_NONE;
        if (any_gnt) begin
            if (sel_we) begin
                dram_wr_en_o      = 1'b1;
                dram_wr_addr_o    = m0_gnt_o ? m0_addr_i    : m1_addr_i;
                dram_wr_data_o    = m0_gnt_o ? m0_wr_data_i : m1_wr_data_i;
                dram_wr_byte_en_o = m0_gnt_o ? m0_byte_en_i : m1_byte_en_i;
            end else begin
                dram_rd_en_o   = 1'b1;
                dram_rd_addr_o = m0_gnt_o ? m0_addr_i : m1_addr_i;
                tag_in         = m0_gnt_o ? OWN_M0 : OWN_M1;
            end
        end
    end

    rd_owner_pipe #(
        .DEPTH (PIPE_DEPTH)
    ) u_rd_owner_pipe (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .tag_i   (tag_in),
        .tag_o   (tag_out)
    );

    assign m0_rd_valid_o = arb_en_q & (tag_out == OWN_M0);
    assign m1_rd_valid_o = arb_en_q & (tag_out == OWN_M1);
    assign m0_rd_data_o  = m0_rd_valid_o ? dram_rd_data_i : '0;
    assign m1_rd_data_o  = m1_rd_valid_o ? dram_rd_data_i : '0;

    a_one_gnt: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(m0_gnt_o && m1_gnt_o));
    a_one_cmd: assert property (@(posedge clk_i) disable iff (!rst_n_i)
        !(dram_rd_en_o && dram_wr_en_o));

endmodule

// File: tb/tb_dram_arbiter.sv
// tb/tb_dram_arbiter.sv - self-checking bench for dram_arbiter at read latencies 1, 2 and 3
module tb_dram_arbiter;

    localparam int NI = 3;   // instance i runs with RD_LAT = i+1
    localparam int MW = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
    logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0, dram_rdata = 0;
    logic [3:0]  m0_be = 0, m1_be = 0;

    logic        g0 [NI], g1 [NI], v0 [NI], v1 [NI], rd_en [NI], wr_en [NI];
    logic [31:0] d0 [NI], d1 [NI], rd_addr [NI], wr_addr [NI], wr_data [NI];
    logic [3:0]  be [NI];

    for (genvar g = 0; g < NI; g++) begin : g_dut
        dram_arbiter #(.XLEN(32), .AW(32), .RD_LAT(g + 1), .MAX_WAIT(MW)) u_dut (
            .clk_i(clk), .rst_n_i(rst_n),
            .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr),
            .m0_wr_data_i(m0_wdata), .m0_byte_en_i(m0_be),
            .m0_gnt_o(g0[g]), .m0_rd_valid_o(v0[g]), .m0_rd_data_o(d0[g]),
            .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr),
            .m1_wr_data_i(m1_wdata), .m1_byte_en_i(m1_be),
            .m1_gnt_o(g1[g]), .m1_rd_valid_o(v1[g]), .m1_rd_data_o(d1[g]),
            .dram_rd_en_o(rd_en[g]), .dram_rd_addr_o(rd_addr[g]),
            .dram_wr_en_o(wr_en[g]), .dram_wr_addr_o(wr_addr[g]),
            .dram_wr_data_o(wr_data[g]), .dram_wr_byte_en_o(be[g]),
            .dram_rd_data_i(dram_rdata)
        );
    end

    int pass_cnt = 0;
    int chk_cnt  = 0;

    function automatic void chk(string nm, logic [127:0] act, logic [127:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h want %0h", nm, act, exp);
    endfunction

    // Reference model: who issued a read in each past cycle (0 none, 1 M0, 2 M1),
    // newest first; plus the enable state and M1's consecutive stall count.
    bit en_m;
    int hist [$];
    int wait_m;
    int cur_issue;

    function automatic void model_reset();
        en_m = 0;
        wait_m = 0;
        hist = '{0, 0, 0, 0};
    endfunction

    task automatic check_cycle();
        bit force1, eg0, eg1, erd, ewr;
        logic [31:0] eaddr, edata;
        logic [3:0]  ebe;
        if (!rst_n) model_reset();
        force1 = 0;
`ifdef DRAM_ARBITER_STARVE_EN
        force1 = (wait_m == MW);
`endif
        eg0 = en_m && m0_req && !force1;
        eg1 = en_m && m1_req && (!m0_req || force1);
        ewr = (eg0 && m0_we) || (eg1 && m1_we);
        erd = (eg0 || eg1) && !ewr;
        eaddr = eg0 ? m0_addr : (eg1 ? m1_addr : 32'h0);
        edata = ewr ? (eg0 ? m0_wdata : m1_wdata) : 32'h0;
        ebe   = ewr ? (eg0 ? m0_be : m1_be) : 4'h0;
        cur_issue = erd ? (eg0 ? 1 : 2) : 0;
        for (int i = 0; i < NI; i++) begin
            int t;
            bit ev0, ev1;
            t = hist[i];
            ev0 = en_m && (t == 1);
            ev1 = en_m && (t == 2);
            chk($sformatf("gnt[%0d]", i), {g0[i], g1[i]}, {eg0, eg1});
            chk($sformatf("dram[%0d]", i),
                {rd_en[i], rd_addr[i], wr_en[i], wr_addr[i], wr_data[i], be[i]},
                {erd, erd ? eaddr : 32'h0, ewr, ewr ? eaddr : 32'h0, edata, ebe});
            chk($sformatf("rdret[%0d]", i), {v0[i], d0[i], v1[i], d1[i]},
                {ev0, ev0 ? dram_rdata : 32'h0, ev1, ev1 ? dram_rdata : 32'h0});
        end
    endtask

    task automatic half();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic fin();
        @(posedge clk);
        if (!rst_n) begin
            model_reset();
        end else begin
            bit g1m;
            g1m = en_m && m1_req && (!m0_req || (wait_m == MW && `ifdef DRAM_ARBITER_STARVE_EN 1 `else 0 `endif));
            hist.push_front(cur_issue);
            void'(hist.pop_back());
            if (!m1_req || g1m) wait_m = 0;
            else if (wait_m < MW) wait_m++;
            en_m = 1;
        end
        #1;
    endtask

    task automatic set_in(bit r0, bit w0, logic [31:0] a0, logic [31:0] dd0, logic [3:0] b0,
                          bit r1, bit w1, logic [31:0] a1, logic [31:0] dd1, logic [3:0] b1);
        m0_req = r0; m0_we = w0; m0_addr = a0; m0_wdata = dd0; m0_be = b0;
        m1_req = r1; m1_we = w1; m1_addr = a1; m1_wdata = dd1; m1_be = b1;
    endtask

    typedef struct {
        bit r0, w0, r1, w1;
        bit eg0, eg1, erd, ewr;
    } vec_t;

    initial begin
        vec_t vt [8];
        int first_g1, cnt_g1;
        vt[0] = '{0,0,0,0, 0,0,0,0};
        vt[1] = '{1,0,0,0, 1,0,1,0};
        vt[2] = '{1,1,0,0, 1,0,0,1};
        vt[3] = '{0,0,1,0, 0,1,1,0};
        vt[4] = '{0,0,1,1, 0,1,0,1};
        vt[5] = '{1,0,1,1, 1,0,1,0};
        vt[6] = '{1,1,1,0, 1,0,0,1};
        vt[7] = '{0,1,0,1, 0,0,0,0};
        model_reset();

        // Reset held with both requesting, then release: no grant in the first cycle.
        set_in(1, 0, 32'h100, 0, 0, 1, 0, 32'h200, 0, 0);
        half(); chk("rst_zero", {g0[0], g1[0], rd_en[0], wr_en[0], rd_addr[0]}, 0); fin();
        rst_n = 1;
        half(); chk("first_no_gnt", {g0[0], g1[0]}, 2'b00); fin();
        half(); chk("m0_wins", {g0[0], g1[0]}, 2'b10); fin();

        // M0 read 0x10, data returns one cycle later on the latency-1 instance.
        set_in(1, 0, 32'h10, 0, 0, 0, 0, 0, 0, 0);
        half(); chk("m0_rd_issue", {rd_en[0], rd_addr[0]}, {1'b1, 32'h10}); fin();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dram_rdata = 32'hDEADBEEF;
        half(); chk("m0_rd_ret", {v0[0], d0[0], v1[0]}, {1'b1, 32'hDEADBEEF, 1'b0}); fin();

        // M0 write then M1 read on consecutive cycles.
        set_in(1, 1, 32'h20, 32'h11223344, 4'b0011, 0, 0, 0, 0, 0);
        half(); chk("m0_wr", {wr_en[0], rd_en[0], wr_addr[0], wr_data[0], be[0]},
                    {1'b1, 1'b0, 32'h20, 32'h11223344, 4'b0011}); fin();
        set_in(0, 0, 0, 0, 0, 1, 0, 32'h20, 0, 0);
        half(); chk("m1_rd", {g1[0], rd_en[0], wr_en[0], rd_addr[0]}, {1'b1, 1'b1, 1'b0, 32'h20}); fin();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dram_rdata = 32'h55667788;
        half(); chk("m1_rd_ret", {v1[0], d1[0], v0[0]}, {1'b1, 32'h55667788, 1'b0}); fin();

        // Latency 3: M0 read, M1 read, write; returns at +3 (M0), +4 (M1), nothing at +5.
        set_in(1, 0, 32'h30, 0, 0, 0, 0, 0, 0, 0); half(); fin();
        set_in(0, 0, 0, 0, 0, 1, 0, 32'h34, 0, 0); half(); fin();
        set_in(1, 1, 32'h38, 32'hA5A5A5A5, 4'hF, 0, 0, 0, 0, 0); half(); fin();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dram_rdata = 32'h01;
        half(); chk("lat3_m0", {v0[2], d0[2], v1[2]}, {1'b1, 32'h01, 1'b0}); fin();
        dram_rdata = 32'h02;
        half(); chk("lat3_m1", {v0[2], v1[2], d1[2]}, {1'b0, 1'b1, 32'h02}); fin();
        half(); chk("lat3_none", {v0[2], v1[2]}, 2'b00); fin();

        // Table of single-cycle grant/issue patterns.
        for (int k = 0; k < 8; k++) begin
            set_in(vt[k].r0, vt[k].w0, 32'h40 + k, 32'hC0 + k, 4'h5,
                   vt[k].r1, vt[k].w1, 32'h80 + k, 32'hE0 + k, 4'hA);
            half();
            chk($sformatf("vec%0d", k), {g0[0], g1[0], rd_en[0], wr_en[0]},
                {vt[k].eg0, vt[k].eg1, vt[k].erd, vt[k].ewr});
            fin();
        end

        // Reset one cycle after an M0 read issue (latency 2): outputs drop, read is lost.
        set_in(1, 0, 32'h50, 0, 0, 0, 0, 0, 0, 0);
        half(); fin();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        dram_rdata = 32'hFFFF0000;
        rst_n = 0;
        #1;
        chk("rst_async", {g0[1], v0[1], d0[1], rd_en[1], wr_en[1]}, 0);
        half(); fin();
        rst_n = 1;
        for (int k = 0; k < 4; k++) begin
            half(); chk($sformatf("rst_drop%0d", k), {v0[1], v1[1]}, 2'b00); fin();
        end

        // Both requesting continuously for 40 cycles.
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0, 0); half(); fin();
        set_in(1, 0, 32'h60, 0, 0, 1, 0, 32'h64, 0, 0);
        first_g1 = -1;
        cnt_g1 = 0;
        for (int k = 1; k <= 40; k++) begin
            half();
            if (g1[0]) begin
                cnt_g1++;
                if (first_g1 < 0) first_g1 = k;
            end
            fin();
        end
`ifdef DRAM_ARBITER_STARVE_EN
        chk("starve_first", first_g1, 16);
        chk("starve_count", cnt_g1, 2);
`else
        chk("starve_first", first_g1, -1);
        chk("starve_count", cnt_g1, 0);
`endif

        // Randomized traffic with occasional resets.
        for (int k = 0; k < 400; k++) begin
            set_in(($urandom_range(0, 99) < 50), $urandom_range(0, 1), $urandom, $urandom, 4'($urandom),
                   ($urandom_range(0, 99) < 60), $urandom_range(0, 1), $urandom, $urandom, 4'($urandom));
            dram_rdata = $urandom;
            rst_n = ($urandom_range(0, 59) != 0);
            half(); fin();
        end
        rst_n = 1;

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
